rca8_sub_serial: RTL and testbench

RCA8_SUB_SERIAL -- requirements
Module: rca8_sub_serial

---
 rtl/rca8_sub_serial_if.sv | 24 ++
 rtl/rca8_sub_serial.sv | 95 +++++++++
 tb/tb_rca8_sub_serial.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rca8_sub_serial_if.sv
// Operand/result bundle for the bit-serial subtractor; master issues start/a/b, slave returns status and result.
interface rca8_sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, d, bout, ovf, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bout, ovf, zero
  );
endinterface

// File: rtl/rca8_sub_serial.sv
// Bit-serial ripple-borrow subtractor d = a - b, one bit per cycle LSB first; done pulses WIDTH+1 edges after start.
// start is accepted in IDLE or DONE only and ignored while busy; results hold until the next DONE entry.
module rca8_sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rca8_sub_serial_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;

  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             a_k;
  logic             b_k;
  logic             diff_k;
  logic             br_nxt;
  logic [WIDTH-1:0] d_full;

  assign a_k    = a_sr[0];
  assign b_k    = b_sr[0];
  assign diff_k = a_k ^ b_k ^ br;
  assign br_nxt = (~a_k & b_k) | (~(a_k ^ b_k) & br);
  // Difference bits enter at the MSB so the word is complete after the last shift.
  assign d_full = {diff_k, d_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      br     <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_full;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // On the final bit a_k/b_k/diff_k are the sign bits of a, b and d.
            state  <= DONE;
            d_q    <= d_full;
            bout_q <= br_nxt;
            ovf_q  <= (a_k ^ b_k) & (diff_k ^ a_k);
            zero_q <= (d_full == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_rca8_sub_serial.sv
// Self-checking bench for rca8_sub_serial: directed corner cases, reset abort, back-to-back and random sweep.
module tb_rca8_sub_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rca8_sub_serial_if #(.WIDTH(8)) bus ();

  rca8_sub_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] md, output logic mbout,
                       output logic movf, output logic mzero);
    int sa;
    int sb;
    int sd;
    sa    = int'($signed(ma));
    sb    = int'($signed(mb));
    sd    = sa - sb;
    md    = 8'(int'(ma) - int'(mb));
    mbout = (int'(ma) < int'(mb));
    movf  = (sd > 127) || (sd < -128);
    mzero = (md == 8'h00);
  endtask

  // Caller sits just after a falling edge. If accepted=1 the start edge already happened.
  // While busy, start/a/b are scrambled to prove they are ignored.
  task automatic run(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                     input bit accepted, input bit chain,
                     input logic [7:0] na, input logic [7:0] nb);
    logic [7:0] ed;
    logic       eb, eo, ez;
    int         lat;
    int         busy_cnt;
    model(ta, tb_, ed, eb, eo, ez);
    if (!accepted) begin
      bus.a     = ta;
      bus.b     = tb_;
      bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    lat       = 1;
    busy_cnt  = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) begin
        busy_cnt++;
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_busycycles"}, busy_cnt, 8);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy_in_done"}, bus.busy, 0);
    chk({tag, "_d"}, bus.d, ed);
    chk({tag, "_bout"}, bus.bout, eb);
    chk({tag, "_ovf"}, bus.ovf, eo);
    chk({tag, "_zero"}, bus.zero, ez);
    if (chain) begin
      bus.a     = na;
      bus.b     = nb;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_chain_busy"}, bus.busy, 1);
      chk({tag, "_chain_done_low"}, bus.done, 0);
    end else begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, bus.done, 0);
      chk({tag, "_idle_busy"}, bus.busy, 0);
      chk({tag, "_hold_d"}, bus.d, ed);
    end
  endtask

  initial begin
    logic [7:0] ra, rb, pa, pb;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_bout", bus.bout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_zero", bus.zero, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("t05m03", 8'h05, 8'h03, 0, 0, 8'h00, 8'h00);
    run("t03m05", 8'h03, 8'h05, 0, 0, 8'h00, 8'h00);
    run("t80m01", 8'h80, 8'h01, 0, 0, 8'h00, 8'h00);
    run("t7Fm FF", 8'h7F, 8'hFF, 0, 0, 8'h00, 8'h00);
    run("tA5mA5", 8'hA5, 8'hA5, 0, 0, 8'h00, 8'h00);
    run("t10m01", 8'h10, 8'h01, 0, 0, 8'h00, 8'h00);
    run("t03m05b", 8'h03, 8'h05, 0, 0, 8'h00, 8'h00);

    // Reset in the middle of SHIFT, between clock edges.
    bus.a     = 8'h55;
    bus.b     = 8'h12;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_d", bus.d, 0);
    chk("midrst_bout", bus.bout, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_zero", bus.zero, 0);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    run("t09m04", 8'h09, 8'h04, 0, 0, 8'h00, 8'h00);

    // Back-to-back: second accept at the DONE edge, second done 9 cycles later.
    run("b2b_1", 8'h3C, 8'h5A, 0, 1, 8'hC3, 8'h21);
    run("b2b_2", 8'hC3, 8'h21, 1, 0, 8'h00, 8'h00);

    // Random chained sweep.
    pa = 8'($urandom);
    pb = 8'($urandom);
    bus.a     = pa;
    bus.b     = pb;
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run("rnd", pa, pb, 1, (i != 1999), ra, rb);
      pa = ra;
      pb = rb;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
